// File: rtl/aes_inv_core_if.sv
// Handshake and data bus for aes_inv_core: ciphertext/key in, plaintext out.
// The master side offers work and accepts results; the slave side is the core.
interface aes_inv_core_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] ciphertext;
  logic [BLK_W-1:0] key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] plaintext;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/aes_inv_core.sv
// Iterative AES-128 decryption core: forward key expansion to rk10, then ten inverse rounds.
// Optional macro AES_INV_KEY_CACHE_EN keeps the last key and its rk10 to skip key expansion.
module aes_inv_core (
  input  logic           clk,
  input  logic           rst_n,
  aes_inv_core_if.slave  bus
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned WRD_W = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_INIT,
    ST_ROUND,
    ST_HOLD
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BLK_W-1:0]   r_data;
  logic [BLK_W-1:0]   r_key;
  logic [BLK_W-1:0]   r_pt;
  logic               r_out_valid;
  logic               r_in_ready;

`ifdef AES_INV_KEY_CACHE_EN
  logic [BLK_W-1:0]   r_cache_key;
  logic [BLK_W-1:0]   r_cache_rk10;
  logic               r_cache_vld;
  logic               w_cache_hit;
  assign w_cache_hit = r_cache_vld && (bus.key == r_cache_key);
`endif

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] y;
    b = gf_inv(x);
    for (int i = 0; i < 8; i++) begin
      y[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
    end
    return y ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    return gf_inv(y ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [WRD_W-1:0] inv_mix_col(input logic [WRD_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Key schedule: one SubWord unit shared by forward expansion and inverse stepping
  logic [WRD_W-1:0] w_k0, w_k1, w_k2, w_k3;
  logic [WRD_W-1:0] w_prev3, w_sw_in, w_sw;
  logic [WRD_W-1:0] w_f0, w_f1, w_f2, w_f3;
  logic [CNT_W-1:0] w_rcon_idx;
  logic [BLK_W-1:0] w_key_fwd, w_key_inv, w_key_next;

  assign w_k0    = r_key[127:96];
  assign w_k1    = r_key[95:64];
  assign w_k2    = r_key[63:32];
  assign w_k3    = r_key[31:0];
  assign w_prev3 = w_k3 ^ w_k2;
  assign w_sw_in = (r_state == ST_KEYEXP) ? w_k3 : w_prev3;

  always_comb begin
    w_rcon_idx = r_cnt;
    if (r_state == ST_KEYEXP)    w_rcon_idx = r_cnt + CNT_W'(1);
    else if (r_state == ST_INIT) w_rcon_idx = CNT_W'(10);
  end

  assign w_sw = {sbox_fwd(w_sw_in[23:16]), sbox_fwd(w_sw_in[15:8]),
                 sbox_fwd(w_sw_in[7:0]),   sbox_fwd(w_sw_in[31:24])}
              ^ {rcon(w_rcon_idx), 24'h000000};

  assign w_f0       = w_k0 ^ w_sw;
  assign w_f1       = w_k1 ^ w_f0;
  assign w_f2       = w_k2 ^ w_f1;
  assign w_f3       = w_k3 ^ w_f2;
  assign w_key_fwd  = {w_f0, w_f1, w_f2, w_f3};
  assign w_key_inv  = {w_k0 ^ w_sw, w_k1 ^ w_k0, w_k2 ^ w_k1, w_prev3};
  assign w_key_next = (r_state == ST_KEYEXP) ? w_key_fwd : w_key_inv;

  // One inverse round on r_data with the round key currently held in r_key
  logic [BLK_W-1:0] w_isr, w_isb, w_ark, w_imc, w_round;

  always_comb begin
    w_isr = '0;
    w_isb = '0;
    w_imc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isr[127 - 8 * (4 * c + r) -: 8] = r_data[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      w_isb[127 - 8 * i -: 8] = sbox_inv(w_isr[127 - 8 * i -: 8]);
    end
    w_ark = w_isb ^ r_key;
    for (int c = 0; c < 4; c++) begin
      w_imc[127 - 32 * c -: 32] = inv_mix_col(w_ark[127 - 32 * c -: 32]);
    end
    w_round = (r_cnt == '0) ? w_ark : w_imc;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_key       <= '0;
      r_pt        <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
      r_cache_key  <= '0;
      r_cache_rk10 <= '0;
      r_cache_vld  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_data     <= bus.ciphertext;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
            if (w_cache_hit) begin
              r_key   <= r_cache_rk10;
              r_state <= ST_INIT;
            end else begin
              r_key       <= bus.key;
              r_cache_key <= bus.key;
              r_cache_vld <= 1'b0;
              r_state     <= ST_KEYEXP;
            end
`else
            r_key   <= bus.key;
            r_state <= ST_KEYEXP;
`endif
          end
        end
        ST_KEYEXP: begin
          r_key <= w_key_next;
          if (r_cnt == CNT_W'(9)) begin
            r_state <= ST_INIT;
`ifdef AES_INV_KEY_CACHE_EN
            r_cache_rk10 <= w_key_next;
            r_cache_vld  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_INIT: begin
          r_data  <= r_data ^ r_key;
          r_key   <= w_key_next;
          r_cnt   <= CNT_W'(9);
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_data <= w_round;
          if (r_cnt == '0) begin
            r_pt        <= w_round;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_key <= w_key_next;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.plaintext = r_pt;

endmodule
